// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: Op encodings, operation latencies and controller states.
package mdu_ctrl_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: 64-bit product (or MADD sum) and quotient/remainder.
// Zero latency; the controller decides when results are committed.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [63:0] mul_o,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o
);

    logic        sgn_mul;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;

    // Extending to 64 bits makes the truncated product correct for both signednesses.
    assign sgn_mul = (op_i == OP_MULT) || (op_i == OP_MADD);
    assign a_ext   = sgn_mul ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
    assign b_ext   = sgn_mul ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
    assign prod    = a_ext * b_ext;
    assign mul_o   = (op_i == OP_MADD) ? ({hi_i, lo_i} + prod) : prod;

    logic        sgn_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] uq;
    logic [31:0] ur;

    // Magnitude division keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
    assign sgn_div = (op_i == OP_DIV);
    assign a_neg   = sgn_div & a_i[31];
    assign b_neg   = sgn_div & b_i[31];
    assign a_mag   = a_neg ? (~a_i + 32'd1) : a_i;
    assign b_mag   = b_neg ? (~b_i + 32'd1) : b_i;
    assign b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign uq      = a_mag / b_safe;
    assign ur      = a_mag % b_safe;
    assign quo_o   = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    assign rem_o   = a_neg ? (~ur + 32'd1) : ur;

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: owns HI/LO and sequences 5-cycle multiplies and 10-cycle divides.
// Busy is registered; Start while Busy or with an unknown Op is dropped.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI_Out,
    output logic [31:0] LO_Out,
    output logic        Busy
);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;

    logic [63:0] mul_res;
    logic [31:0] quo_res;
    logic [31:0] rem_res;

    mdu_arith u_arith (
        .op_i  (op_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .mul_o (mul_res),
        .quo_o (quo_res),
        .rem_o (rem_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (is_mul_op(Op) || is_div_op(Op)) begin
                        op_d    = Op;
                        a_d     = A;
                        b_d     = B;
                        busy_d  = 1'b1;
                        cnt_d   = is_mul_op(Op) ? MUL_CYCLES : DIV_CYCLES;
                        state_d = is_mul_op(Op) ? ST_MUL : ST_DIV;
                    end else if (Op == OP_MTHI) begin
                        hi_d = A;
                    end else if (Op == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                cnt_d = cnt_q - 4'd1;
                // Counter hits zero on this edge: commit and free the unit.
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (state_q == ST_MUL) begin
                        {hi_d, lo_d} = mul_res;
                    end else if (b_q != 32'd0) begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign HI_Out = hi_q;
    assign LO_Out = lo_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: Busy timing, HI/LO results, hazards and reset abort.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI_Out;
    logic [31:0] LO_Out;
    logic        Busy;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    mdu_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .Op     (Op),
        .A      (A),
        .B      (B),
        .HI_Out (HI_Out),
        .LO_Out (LO_Out),
        .Busy   (Busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input logic [31:0] eh, input logic [31:0] el);
        chk({tag, "_hi"}, HI_Out, eh);
        chk({tag, "_lo"}, LO_Out, el);
    endtask

    // Issue one op in the current (idle) cycle; check n busy cycles with HI/LO held, then results.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] eh, input logic [31:0] el);
        Start = 1'b1; Op = op; A = a; B = b;
        step();
        Start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk1({tag, "_busy"}, Busy, 1'b1);
            chk_regs({tag, "_hold"}, cur_hi, cur_lo);
            step();
        end
        chk1({tag, "_done"}, Busy, 1'b0);
        chk_regs(tag, eh, el);
        cur_hi = eh;
        cur_lo = el;
    endtask

    task automatic mt_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] eh, input logic [31:0] el);
        Start = 1'b1; Op = op; A = a; B = 32'd0;
        step();
        Start = 1'b0;
        chk1({tag, "_busy"}, Busy, 1'b0);
        chk_regs(tag, eh, el);
        cur_hi = eh;
        cur_lo = el;
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0;
        cur_hi = 32'd0; cur_lo = 32'd0;
        #1;
        chk1("rst_busy", Busy, 1'b0);
        chk_regs("rst", 32'd0, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        chk1("idle_busy", Busy, 1'b0);

        run_op("mult",  OP_MULT,  32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
        run_op("div",   OP_DIV,   32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu",  OP_DIVU,  32'd7, 32'd2, 10, 32'd1, 32'd3);

        mt_op("mthi11", OP_MTHI, 32'h11, 32'h11, 32'd3);
        mt_op("mtlo22", OP_MTLO, 32'h22, 32'h11, 32'h22);
        run_op("divz",  OP_DIVU,  32'd5, 32'd0, 10, 32'h11, 32'h22);
        run_op("divovf", OP_DIV,  32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);

        mt_op("mthi0",  OP_MTHI, 32'd0, 32'd0, 32'h80000000);
        mt_op("mtlo_f", OP_MTLO, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF);
        run_op("madd1", OP_MADD, 32'd1, 32'd1, 5, 32'd1, 32'd0);
        run_op("maddneg", OP_MADD, 32'hFFFFFFFF, 32'd3, 5, 32'd0, 32'hFFFFFFFD);

        Start = 1'b1; Op = 3'd7; A = 32'h1234; B = 32'd9;
        step();
        Start = 1'b0;
        chk1("badop_busy", Busy, 1'b0);
        chk_regs("badop", 32'd0, 32'hFFFFFFFD);

        // Start DIV pulsed during a MULT must not disturb it.
        Start = 1'b1; Op = OP_MULT; A = 32'd3; B = 32'd5;
        step();
        Start = 1'b0;
        chk1("haz_c1", Busy, 1'b1);
        step();
        chk1("haz_c2", Busy, 1'b1);
        Start = 1'b1; Op = OP_DIV; A = 32'd100; B = 32'd7;
        step();
        Start = 1'b0;
        chk1("haz_c3", Busy, 1'b1);
        chk_regs("haz_hold", 32'd0, 32'hFFFFFFFD);
        step();
        chk1("haz_c4", Busy, 1'b1);
        step();
        chk1("haz_c5", Busy, 1'b1);
        step();
        chk1("haz_done", Busy, 1'b0);
        chk_regs("haz", 32'd0, 32'd15);
        cur_hi = 32'd0; cur_lo = 32'd15;
        run_op("b2b_divu", OP_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);

        // Reset in the middle of a divide aborts it.
        Start = 1'b1; Op = OP_DIV; A = 32'd100; B = 32'd7;
        step();
        Start = 1'b0;
        chk1("rab_c1", Busy, 1'b1);
        step();
        step();
        step();
        chk1("rab_c4", Busy, 1'b1);
        reset = 1'b1;
        #1;
        chk1("rab_busy", Busy, 1'b0);
        chk_regs("rab_now", 32'd0, 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk1("rab_after_busy", Busy, 1'b0);
        chk_regs("rab_after", 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
